// File: rtl/iscore_pkg.sv
// Shared iscore definitions: transport state encoding and the
// beat/tempo widths shared with playing_notes_manager.
package iscore_pkg;

    localparam int NOTES_STATE_SIZE = 72;
    localparam int BEAT_BITS        = 7;
    localparam int TEMPO_BITS       = 24;
    localparam int SCAN_CYCLES      = NOTES_STATE_SIZE + 1;
    localparam int CLICK_CYCLES     = 1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } xport_state_e;

endpackage

// File: rtl/beat_timer.sv
// Loadable tick counter with enable, sync clear and terminal-count flag.
// Counts up (wrapping) or down (saturating at zero) depending on DOWN.
module beat_timer #(
    parameter int WIDTH = 24,
    parameter bit DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] count;

    // Counter register: clear beats load beats enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (DOWN) begin
                if (count != '0) begin
                    count <= count - ONE;
                end
            end else begin
                count <= count + ONE;
            end
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/beat_sequencer.sv
// Transport controller: tempo-driven beat strobes with play/pause/stop/loop.
// Optional metronome click output enabled by BEAT_SEQUENCER_METRONOME_EN.
module beat_sequencer #(
    parameter int BEAT_BITS   = iscore_pkg::BEAT_BITS,
    parameter int TEMPO_BITS  = iscore_pkg::TEMPO_BITS,
    parameter int SCAN_CYCLES = iscore_pkg::SCAN_CYCLES
`ifdef BEAT_SEQUENCER_METRONOME_EN
    ,
    parameter int CLICK_CYCLES = iscore_pkg::CLICK_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [BEAT_BITS-1:0]  song_len,
    input  logic [TEMPO_BITS-1:0] clks_per_beat,
    output logic [BEAT_BITS-1:0]  cur_beat,
    output logic                  new_beat,
    output logic                  notes_valid,
`ifdef BEAT_SEQUENCER_METRONOME_EN
    output logic                  metronome,
`endif
    output logic [1:0]            state
);

    import iscore_pkg::*;

    localparam logic [TEMPO_BITS-1:0] SCAN_T = TEMPO_BITS'(SCAN_CYCLES);
    localparam logic [TEMPO_BITS-1:0] ONE_T  = 1;
    localparam logic [BEAT_BITS:0]    ONE_B  = 1;

    xport_state_e          state_q;
    xport_state_e          state_n;
    logic [BEAT_BITS-1:0]  beat_q;
    logic [BEAT_BITS-1:0]  beat_n;
    logic                  nb_q;
    logic                  nb_n;
    logic [TEMPO_BITS-1:0] lat_q;
    logic [TEMPO_BITS-1:0] tempo_clamp;
    logic                  tick_clr;
    logic                  tick_en;
    logic                  tick_tc;
    logic                  settle_en;
    logic                  settle_tc;
    logic                  last_beat;

    // Beats shorter than the manager scan are stretched to the scan length.
    assign tempo_clamp = (clks_per_beat < SCAN_T) ? SCAN_T : clks_per_beat;

    // A shrunken song_len makes any beat at or past the end the last one.
    assign last_beat = ({1'b0, beat_q} + ONE_B) >= {1'b0, song_len};

    // Next-state and beat-advance decode; stop beats pause beats play.
    always_comb begin
        state_n  = state_q;
        beat_n   = beat_q;
        nb_n     = 1'b0;
        tick_clr = 1'b0;
        tick_en  = 1'b0;
        if (stop) begin
            state_n  = IDLE;
            beat_n   = '0;
            tick_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (!pause && play && song_len != '0) begin
                        state_n  = PLAYING;
                        beat_n   = '0;
                        nb_n     = 1'b1;
                        tick_clr = 1'b1;
                    end
                end
                PLAYING: begin
                    if (pause) begin
                        state_n = PAUSED;
                    end else if (tick_tc) begin
                        tick_clr = 1'b1;
                        if (!last_beat) begin
                            beat_n = beat_q + ONE_B[BEAT_BITS-1:0];
                            nb_n   = 1'b1;
                        end else if (loop_en) begin
                            beat_n = '0;
                            nb_n   = 1'b1;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        tick_en = 1'b1;
                    end
                end
                PAUSED: begin
                    if (!pause && play) begin
                        state_n = PLAYING;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Settle and click counters only run in live PLAYING cycles.
    assign settle_en = (state_q == PLAYING) && !stop && !pause;

    // Transport registers; tempo is captured with each new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            nb_q    <= 1'b0;
            lat_q   <= SCAN_T;
        end else begin
            state_q <= state_n;
            beat_q  <= beat_n;
            nb_q    <= nb_n;
            if (nb_n) begin
                lat_q <= tempo_clamp;
            end
        end
    end

    beat_timer #(
        .WIDTH (TEMPO_BITS),
        .DOWN  (1'b0)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tick_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (tick_en),
        .term     (lat_q - ONE_T),
        .tc       (tick_tc)
    );

    beat_timer #(
        .WIDTH (TEMPO_BITS),
        .DOWN  (1'b1)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (stop),
        .load     (nb_n),
        .load_val (SCAN_T),
        .en       (settle_en),
        .term     ('0),
        .tc       (settle_tc)
    );

    assign cur_beat    = beat_q;
    assign new_beat    = nb_q;
    assign state       = state_q;
    assign notes_valid = settle_tc &&
                         (state_q == PLAYING || state_q == PAUSED);

`ifdef BEAT_SEQUENCER_METRONOME_EN
    localparam logic [TEMPO_BITS-1:0] CLICK_T = TEMPO_BITS'(CLICK_CYCLES);

    logic [TEMPO_BITS-1:0] click_len;
    logic                  click_tc;

    // Click never spans a whole beat so each beat starts a fresh pulse.
    assign click_len = ((tempo_clamp - ONE_T) < CLICK_T) ?
                       (tempo_clamp - ONE_T) : CLICK_T;

    beat_timer #(
        .WIDTH (TEMPO_BITS),
        .DOWN  (1'b1)
    ) u_click (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (stop),
        .load     (nb_n),
        .load_val (click_len),
        .en       (settle_en),
        .term     ('0),
        .tc       (click_tc)
    );

    assign metronome = (state_q == PLAYING) && !click_tc;
`endif

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
Transport controller that sequences playing_notes_manager. It generates cur_beat and the one-cycle new_beat strobe from a programmable tempo, and implements play, pause, stop and loop. It guarantees every beat lasts long enough for the manager's notes scan to complete, and flags when the playing-notes array is settled. It sits between the user-control/UI logic and the note datapath.

Parameters:
BEAT_BITS, 7, width of cur_beat and song_len
TEMPO_BITS, 24, width of clks_per_beat
SCAN_CYCLES, 73, clocks the manager needs after new_beat to finish its scan (NOTES_STATE_SIZE+1); also the minimum beat length
CLICK_CYCLES, 1000, metronome pulse length (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
play  in  1  one-cycle request: start from IDLE/DONE, or resume from PAUSED
pause  in  1  one-cycle request: freeze in PLAYING
stop  in  1  one-cycle request: return to IDLE
loop_en  in  1  level; wrap to beat 0 at song end instead of stopping
song_len  in  BEAT_BITS  number of beats in the song
clks_per_beat  in  TEMPO_BITS  tempo, clocks per beat
cur_beat  out  BEAT_BITS  current beat, registered
new_beat  out  1  one-cycle strobe, coincident with the first cycle of the new cur_beat value
notes_valid  out  1  manager output is settled for cur_beat
state  out  2  0=IDLE, 1=PLAYING, 2=PAUSED, 3=DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cur_beat=0; new_beat=0; notes_valid=0; tick=0; settle counter=0; latched tempo=SCAN_CYCLES.
- Request priority within one cycle: stop > pause > play.
- IDLE/DONE + play with song_len!=0:
  - Next cycle: state=PLAYING, cur_beat=0, new_beat=1, tick=0.
  - play with song_len==0 is ignored and the state is unchanged.
- Tempo latch:
  - clks_per_beat is latched at every new_beat.
  - The latched value is max(clks_per_beat, SCAN_CYCLES); 0 is also clamped.
  - Mid-beat changes take effect at the next beat.
- PLAYING:
  - tick increments each clock.
  - When tick==latched-1: tick goes to 0 and the beat advances:
    - If cur_beat < song_len-1: cur_beat+1, with new_beat=1 on the following cycle-boundary.
    - If cur_beat == song_len-1 and loop_en=1: cur_beat=0, new_beat=1.
    - If cur_beat == song_len-1 and loop_en=0: state=DONE, cur_beat holds, new_beat stays 0.
  - Beat period is exactly latched clocks; new_beat pulses are spaced exactly latched clocks apart.
- PAUSED:
  - pause in PLAYING gives state=PAUSED; tick and cur_beat freeze; notes_valid unchanged.
  - play in PAUSED gives PLAYING, resuming tick from its frozen value with no new_beat.
  - pause in PAUSED and in other states is ignored.
- stop (any state): next cycle state=IDLE, cur_beat=0, tick=0, notes_valid=0, no new_beat.
- song_len shrinking while playing: if cur_beat >= song_len at a beat boundary, the wrap/end rule applies as if at the last beat.
- notes_valid:
  - The settle counter loads SCAN_CYCLES in the cycle new_beat=1 and decrements to 0.
  - notes_valid=1 when the counter==0 and state is PLAYING or PAUSED.
  - It goes 0 in the new_beat cycle.
  - It is first high exactly SCAN_CYCLES cycles after new_beat.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: BEAT_SEQUENCER_METRONOME_EN.
- With the macro defined:
  - Extra output metronome (1 bit).
  - metronome is high for min(CLICK_CYCLES, latched-1) cycles starting at each new_beat while PLAYING.
  - It is held low in PAUSED, IDLE and DONE.
  - It goes low on reset.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package iscore_pkg:
  - transport state enum (IDLE/PLAYING/PAUSED/DONE);
  - BEAT_BITS, TEMPO_BITS and NOTES_STATE_SIZE-derived SCAN_CYCLES constants, shared with playing_notes_manager.
- One natural sub-module: beat_timer.
  - Loadable tick counter with enable, sync clear, and terminal-count output.
  - Instantiated for beat timing.
  - Also reusable for the settle and metronome counters.

Test Plan:
- Reset mid-PLAYING at cur_beat=5 -> all outputs return to their reset values asynchronously; notes_valid=0.
- song_len=4, clks_per_beat=100, loop_en=0, play -> new_beat at cycles 1, 101, 201, 301; cur_beat 0..3; state=DONE at cycle 401; no fifth new_beat.
- Same setup with loop_en=1 -> the fifth new_beat at cycle 401 has cur_beat=0.
- clks_per_beat=10 (below SCAN_CYCLES=73) -> beats are 73 cycles apart; notes_valid rises 73 cycles after each new_beat.
- Pause at tick 40 of beat 2, hold 500 cycles, then play -> the next new_beat occurs 60 cycles after resume; cur_beat=3; no extra strobe on resume.
- play and stop in the same cycle while PLAYING -> IDLE, cur_beat=0; play with song_len=0 -> stays IDLE.
